mux_arbiter: RTL

Round-robin arbiter that shares the datapath's 16-bit 4:1 operand mux among four requesters. It samples per-requester request lines and issues a registered one-hot grant. It drives the 2-bit mux select so the granted source's data is steered onto the shared bus. Grants are held while the owner keeps requesting, with zero-bubble handoff to the next requester.

---
 rtl/mux_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for four requesters sharing a 16-bit 4:1 operand mux.
// Optional burst limiter enabled by defining ARB_BURST_LIMIT_EN.
module mux_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] mux_select,
  output logic       bus_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic       preempt_q, preempt_d;

  logic [2:0] pick_new_s;
  logic [2:0] pick_other_s;
  logic       new_grant_s;
  logic       limit_hit_s;

  // Returns {found, index} of the first set mask bit at base+1, base+2, base+3, base.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = base + 2'(k);
      if (mask[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign pick_new_s   = rr_pick(req, last_q);
  assign pick_other_s = rr_pick(req & ~onehot(sel_q), sel_q);

  // Next-state, next-grant and handoff decisions.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    valid_d     = valid_q;
    preempt_d   = 1'b0;
    new_grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_new_s[2]) begin
          state_d     = ST_BUSY;
          sel_d       = pick_new_s[1:0];
          last_d      = pick_new_s[1:0];
          gnt_d       = onehot(pick_new_s[1:0]);
          valid_d     = 1'b1;
          new_grant_s = 1'b1;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (!req[sel_q]) begin
          if (pick_other_s[2]) begin
            sel_d       = pick_other_s[1:0];
            last_d      = pick_other_s[1:0];
            gnt_d       = onehot(pick_other_s[1:0]);
            valid_d     = 1'b1;
            new_grant_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else if (limit_hit_s && pick_other_s[2]) begin
          // Revoked owner becomes the lowest-priority requester.
          sel_d       = pick_other_s[1:0];
          last_d      = sel_q;
          gnt_d       = onehot(pick_other_s[1:0]);
          valid_d     = 1'b1;
          preempt_d   = 1'b1;
          new_grant_s = 1'b1;
        end else begin
          gnt_d   = onehot(sel_q);
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd3;
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST_LAST = (MAX_BURST > 32'd1) ? 8'(MAX_BURST - 32'd1) : 8'd0;

  logic [7:0] cnt_q, cnt_d;

  // Burst counter: cleared on each new grant, saturating at MAX_BURST-1.
  always_comb begin
    cnt_d = cnt_q;
    if (new_grant_s) begin
      cnt_d = 8'd0;
    end else if ((state_q == ST_BUSY) && (cnt_q < BURST_LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit_s = (state_q == ST_BUSY) && (cnt_q >= BURST_LAST);
`else
  logic unused_max_burst_s;
  assign unused_max_burst_s = ^8'(MAX_BURST) | new_grant_s;
  assign limit_hit_s        = 1'b0;
`endif

  assign gnt        = gnt_q;
  assign mux_select = sel_q;
  assign bus_valid  = valid_q;
  assign preempt    = preempt_q;

endmodule
